// File: rtl/keypad_scanner_if.sv
// ---------------------------------------------------------------------------
// keypad_scanner_if
//
// Purpose: bundles the scan strobe, the keypad matrix lines and the decoded
// key outputs of keypad_scanner into a single port.
//
// Signals:
//   scan_en   - one-clk scan strobe from the upstream prescaler
//   row_n     - keypad row lines, active-low, asynchronous to clk
//   col_n     - keypad column drive, active-low, one-hot-low
//   key_code  - accepted key code (column*4 + row)
//   key_valid - one-clk pulse when key_code is updated
//   key_held  - high while the accepted key remains pressed
//
// Modports:
//   slave  - the scanner itself (consumes strobe/rows, drives columns/keys)
//   master - the surrounding system / keypad (drives strobe/rows)
// ---------------------------------------------------------------------------
interface keypad_scanner_if;
  logic       scan_en;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport slave (
    input  scan_en,
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport master (
    output scan_en,
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Purpose: scans a 4x4 active-low keypad matrix one column per scan strobe,
// debounces presses and releases, and reports the accepted key.
//
// Ports:
//   clk    - system clock (50 MHz)
//   reset  - asynchronous active-high reset
//   kp     - keypad_scanner_if.slave bundle:
//              scan_en (in), row_n[3:0] (in), col_n[3:0] (out),
//              key_code[3:0] (out), key_valid (out), key_held (out)
//
// Parameter:
//   DEBOUNCE_SCANS - consecutive qualifying strobes needed to accept a press
//                    and, separately, to accept a release (1..15)
//
// Behaviour summary:
//   IDLE     : rotate the driven column on each strobe until a row reads low.
//   DEBOUNCE : column frozen; count strobes that see the same key.
//   HELD     : column frozen; count strobes with no row low to detect release.
// ---------------------------------------------------------------------------
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.slave  kp
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  localparam logic [3:0] SCANS = 4'(DEBOUNCE_SCANS);

  // -------------------------------------------------------------------------
  // Row synchronizer. It samples every clock so that the value seen on a
  // strobe is always a settled two-flop copy of the pins; only the scan
  // state below is gated by scan_en.
  // -------------------------------------------------------------------------
  logic [3:0] row_meta_reg;
  logic [3:0] row_sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= kp.row_n;
      row_sync_reg <= row_meta_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Scan state
  // -------------------------------------------------------------------------
  logic [1:0] state_reg,     state_next;
  logic [1:0] col_reg,       col_next;
  logic [3:0] cand_reg,      cand_next;
  logic [3:0] press_cnt_reg, press_cnt_next;
  logic [3:0] rel_cnt_reg,   rel_cnt_next;
  logic [3:0] key_code_reg,  key_code_next;
  logic       key_valid_reg, key_valid_next;
  logic       key_held_reg,  key_held_next;

  // -------------------------------------------------------------------------
  // Hit decode: any low row is a hit, and the lowest-index low row wins when
  // several keys in the driven column are down together.
  // -------------------------------------------------------------------------
  logic       hit;
  logic [1:0] hit_row;
  logic [3:0] cand_code;

  always_comb begin
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_reg[i]) begin
        hit_row = 2'(i);
      end
    end
  end

  assign hit       = ~(&row_sync_reg);
  assign cand_code = {col_reg, hit_row};

  // Saturating increments: counts stop at SCANS and can never wrap.
  logic [3:0] press_inc;
  logic [3:0] rel_inc;

  assign press_inc = (press_cnt_reg >= SCANS) ? SCANS : press_cnt_reg + 4'd1;
  assign rel_inc   = (rel_cnt_reg   >= SCANS) ? SCANS : rel_cnt_reg   + 4'd1;

  // -------------------------------------------------------------------------
  // Next-state logic. Nothing moves outside a strobe except key_valid, which
  // is a single-cycle pulse and therefore defaults back to 0.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    cand_next      = cand_reg;
    press_cnt_next = press_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;

    if (kp.scan_en) begin
      case (state_reg)
        ST_IDLE: begin
          if (!hit) begin
            col_next = col_reg + 2'd1;
          end else begin
            cand_next      = cand_code;
            press_cnt_next = 4'd1;
            rel_cnt_next   = 4'd0;
            if (SCANS == 4'd1) begin
              // A single qualifying strobe is already enough to accept.
              key_code_next  = cand_code;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              state_next     = ST_HELD;
            end else begin
              state_next = ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          // The column is frozen here, so a different code can only mean a
          // different row in the same column; treat it like a bounce.
          if (hit && (cand_code == cand_reg)) begin
            press_cnt_next = press_inc;
            if (press_inc == SCANS) begin
              key_code_next  = cand_reg;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
              rel_cnt_next   = 4'd0;
              state_next     = ST_HELD;
            end
          end else begin
            press_cnt_next = 4'd0;
            col_next       = col_reg + 2'd1;
            state_next     = ST_IDLE;
          end
        end

        ST_HELD: begin
          if (hit) begin
            rel_cnt_next = 4'd0;
          end else if (rel_inc == SCANS) begin
            rel_cnt_next   = 4'd0;
            press_cnt_next = 4'd0;
            key_held_next  = 1'b0;
            col_next       = col_reg + 2'd1;
            state_next     = ST_IDLE;
          end else begin
            rel_cnt_next = rel_inc;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean idle scan.
          press_cnt_next = 4'd0;
          rel_cnt_next   = 4'd0;
          key_held_next  = 1'b0;
          state_next     = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Reset aborts any press in progress; key_valid is forced
  // low so no acceptance can leak out across reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      col_reg       <= 2'd0;
      cand_reg      <= 4'd0;
      press_cnt_reg <= 4'd0;
      rel_cnt_reg   <= 4'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      cand_reg      <= cand_next;
      press_cnt_reg <= press_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign kp.col_n     = ~(4'b0001 << col_reg);
  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;

endmodule
